// File: rtl/gb_cpu_pkg.sv
// Shared control-unit types: sequencer states, vector constants and one-hot reset values.
// Pure declarations; no logic, no latency.
package gb_cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALT     = 2'd1,
        DISPATCH = 2'd2
    } state_t;

    localparam logic [7:0] VECTOR_BASE      = 8'h40;
    localparam int         DISPATCH_MCYCLES = 5;
    localparam logic [3:0] STEP_RST         = 4'b0001;
    localparam logic [7:0] COUNT_RST        = 8'b0000_0001;

    // Vectors are spaced 8 bytes apart; the sum wraps within the low address byte.
    function automatic logic [7:0] int_vector(input logic [7:0] base, input logic [2:0] idx);
        return base + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/int_priority_encoder.sv
// Lowest-index-wins encoder over pending interrupt requests.
// Purely combinational, zero latency, no flow control.
module int_priority_encoder #(
    parameter int INT_LINES = 5
) (
    input  logic [INT_LINES-1:0] i_req,
    output logic [INT_LINES-1:0] o_grant,
    output logic [2:0]           o_index,
    output logic                 o_valid
);

    always_comb begin
        o_grant = '0;
        o_index = 3'd0;
        o_valid = 1'b0;
        // Scan downward so the last hit, the lowest set bit, is the one kept.
        for (int i = INT_LINES - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_index    = 3'(i);
                o_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle sequencer with IME, delayed EI, HALT (incl. HALT bug) and 5 M-cycle interrupt dispatch.
// All outputs registered and advance only on i_Enable ticks; i_Enable low freezes every output.
module cycle_sequencer #(
    parameter int         INT_LINES   = 5,
    parameter logic [7:0] VECTOR_BASE = gb_cpu_pkg::VECTOR_BASE
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Enable,
    input  logic                 i_IR_Fetch,
    input  logic                 i_EI,
    input  logic                 i_EI_Now,
    input  logic                 i_DI,
    input  logic                 i_HALT,
    input  logic [INT_LINES-1:0] i_IF,
    input  logic [INT_LINES-1:0] i_IE,
    output logic [3:0]           o_Cycle_Step,
    output logic [7:0]           o_Cycle_Count,
    output logic                 o_INT_Active,
    output logic [7:0]           o_INT_Vector,
    output logic [INT_LINES-1:0] o_INT_Ack,
    output logic                 o_IME,
    output logic                 o_Halted,
    output logic                 o_HALT_Bug
);

    localparam int LAST_MC = gb_cpu_pkg::DISPATCH_MCYCLES - 1;
    localparam int VEC_MC  = gb_cpu_pkg::DISPATCH_MCYCLES - 2;

    gb_cpu_pkg::state_t r_state;

    logic [3:0]           r_step;
    logic [7:0]           r_count;
    logic                 r_ime;
    logic                 r_eip;
    logic                 r_active;
    logic                 r_halted;
    logic                 r_halt_bug;
    logic [7:0]           r_vector;
    logic [INT_LINES-1:0] r_ack;

    logic [INT_LINES-1:0] w_req;
    logic [INT_LINES-1:0] w_grant;
    logic [2:0]           w_index;
    logic                 w_valid;
    logic                 w_pend;
    logic                 w_ime_eff;

    always_comb begin
        w_req     = i_IF & i_IE;
        w_pend    = |w_req;
        w_ime_eff = r_ime | r_eip;
    end

    int_priority_encoder #(
        .INT_LINES (INT_LINES)
    ) u_prio (
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_index (w_index),
        .o_valid (w_valid)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= gb_cpu_pkg::RUN;
            r_step     <= gb_cpu_pkg::STEP_RST;
            r_count    <= gb_cpu_pkg::COUNT_RST;
            r_ime      <= 1'b0;
            r_eip      <= 1'b0;
            r_active   <= 1'b0;
            r_halted   <= 1'b0;
            r_halt_bug <= 1'b0;
            r_vector   <= 8'h00;
            r_ack      <= '0;
        end else if (i_Enable) begin
            r_step <= {r_step[2:0], r_step[3]};
            r_ack  <= '0;

            // Source is resolved at the first T-state of dispatch M4; an IF cleared by then cancels it.
            if (r_state == gb_cpu_pkg::DISPATCH && r_step[0] && r_count[VEC_MC]) begin
                if (w_valid) begin
                    r_vector <= gb_cpu_pkg::int_vector(VECTOR_BASE, w_index);
                    r_ack    <= w_grant;
                end else begin
                    r_vector <= 8'h00;
                end
            end

            if (r_step[3]) begin
                r_halt_bug <= 1'b0;
                case (r_state)
                    gb_cpu_pkg::RUN: begin
                        if (!i_IR_Fetch) begin
                            if (!r_count[7]) begin
                                r_count <= r_count << 1;
                            end
                        end else begin
                            r_count <= gb_cpu_pkg::COUNT_RST;
                            if (i_DI) begin
                                r_ime <= 1'b0;
                                r_eip <= 1'b0;
                            end else if (w_ime_eff && w_pend) begin
                                r_state  <= gb_cpu_pkg::DISPATCH;
                                r_active <= 1'b1;
                                r_ime    <= i_EI_Now;
                                r_eip    <= i_EI;
                            end else begin
                                if (i_HALT) begin
                                    if (!w_pend) begin
                                        r_state  <= gb_cpu_pkg::HALT;
                                        r_halted <= 1'b1;
                                    end else begin
                                        r_halt_bug <= 1'b1;
                                    end
                                end
                                // A pending EI becomes live here, so it covers the next instruction's end.
                                r_ime <= r_ime | r_eip | i_EI_Now;
                                r_eip <= i_EI;
                            end
                        end
                    end

                    gb_cpu_pkg::HALT: begin
                        r_count <= gb_cpu_pkg::COUNT_RST;
                        if (w_pend) begin
                            r_halted <= 1'b0;
                            if (r_ime) begin
                                r_state  <= gb_cpu_pkg::DISPATCH;
                                r_active <= 1'b1;
                                r_ime    <= 1'b0;
                                r_eip    <= 1'b0;
                            end else begin
                                r_state <= gb_cpu_pkg::RUN;
                            end
                        end
                    end

                    gb_cpu_pkg::DISPATCH: begin
                        if (r_count[LAST_MC]) begin
                            r_state  <= gb_cpu_pkg::RUN;
                            r_active <= 1'b0;
                            r_count  <= gb_cpu_pkg::COUNT_RST;
                        end else begin
                            r_count <= r_count << 1;
                        end
                    end

                    default: begin
                        r_state  <= gb_cpu_pkg::RUN;
                        r_count  <= gb_cpu_pkg::COUNT_RST;
                        r_active <= 1'b0;
                        r_halted <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_Cycle_Step  = r_step;
        o_Cycle_Count = r_count;
        o_INT_Active  = r_active;
        o_INT_Vector  = r_vector;
        o_INT_Ack     = r_ack;
        o_IME         = r_ime;
        o_Halted      = r_halted;
        o_HALT_Bug    = r_halt_bug;
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: hand-computed expectations checked with immediate assertions.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cycle_sequencer;

    logic       i_Clk;
    logic       i_Reset;
    logic       i_Enable;
    logic       i_IR_Fetch;
    logic       i_EI;
    logic       i_EI_Now;
    logic       i_DI;
    logic       i_HALT;
    logic [4:0] i_IF;
    logic [4:0] i_IE;
    logic [3:0] o_Cycle_Step;
    logic [7:0] o_Cycle_Count;
    logic       o_INT_Active;
    logic [7:0] o_INT_Vector;
    logic [4:0] o_INT_Ack;
    logic       o_IME;
    logic       o_Halted;
    logic       o_HALT_Bug;

    int errors = 0;
    int checks = 0;

    cycle_sequencer #(
        .INT_LINES   (5),
        .VECTOR_BASE (8'h40)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Reset       (i_Reset),
        .i_Enable      (i_Enable),
        .i_IR_Fetch    (i_IR_Fetch),
        .i_EI          (i_EI),
        .i_EI_Now      (i_EI_Now),
        .i_DI          (i_DI),
        .i_HALT        (i_HALT),
        .i_IF          (i_IF),
        .i_IE          (i_IE),
        .o_Cycle_Step  (o_Cycle_Step),
        .o_Cycle_Count (o_Cycle_Count),
        .o_INT_Active  (o_INT_Active),
        .o_INT_Vector  (o_INT_Vector),
        .o_INT_Ack     (o_INT_Ack),
        .o_IME         (o_IME),
        .o_Halted      (o_Halted),
        .o_HALT_Bug    (o_HALT_Bug)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // One M-cycle starting at step 0001; i_IR_Fetch is raised only for the boundary tick.
    task automatic mcycle(input logic fetch);
        i_IR_Fetch = 1'b0;
        repeat (3) tick();
        i_IR_Fetch = fetch;
        tick();
        i_IR_Fetch = 1'b0;
    endtask

    initial begin
        i_Reset    = 1'b1;
        i_Enable   = 1'b1;
        i_IR_Fetch = 1'b0;
        i_EI       = 1'b0;
        i_EI_Now   = 1'b0;
        i_DI       = 1'b0;
        i_HALT     = 1'b0;
        i_IF       = 5'b0;
        i_IE       = 5'b0;
        repeat (2) tick();
        i_Reset = 1'b0;

        chk("rst_step",   o_Cycle_Step,  4'b0001);
        chk("rst_count",  o_Cycle_Count, 8'h01);
        chk("rst_active", o_INT_Active,  1'b0);
        chk("rst_vector", o_INT_Vector,  8'h00);
        chk("rst_ack",    o_INT_Ack,     5'b0);
        chk("rst_ime",    o_IME,         1'b0);
        chk("rst_halted", o_Halted,      1'b0);
        chk("rst_bug",    o_HALT_Bug,    1'b0);

        // 3 M-cycle instruction
        tick();
        chk("step_t1", o_Cycle_Step, 4'b0010);
        tick();
        tick();
        chk("step_t3", o_Cycle_Step, 4'b1000);
        tick();
        chk("step_wrap", o_Cycle_Step, 4'b0001);
        chk("count_m2",  o_Cycle_Count, 8'h02);
        mcycle(1'b0);
        chk("count_m3", o_Cycle_Count, 8'h04);
        mcycle(1'b1);
        chk("count_restart", o_Cycle_Count, 8'h01);
        chk("ins_active",    o_INT_Active, 1'b0);
        chk("ins_ack",       o_INT_Ack, 5'b0);

        // enable low freezes everything
        i_Enable = 1'b0;
        repeat (3) tick();
        chk("hold_step",  o_Cycle_Step, 4'b0001);
        chk("hold_count", o_Cycle_Count, 8'h01);
        i_Enable = 1'b1;

        // EI is delayed by one instruction; DI clears; DI beats EI
        i_EI = 1'b1;
        mcycle(1'b1);
        i_EI = 1'b0;
        chk("ei_delayed", o_IME, 1'b0);
        mcycle(1'b1);
        chk("ei_live", o_IME, 1'b1);
        i_DI = 1'b1;
        mcycle(1'b1);
        i_DI = 1'b0;
        chk("di_clear", o_IME, 1'b0);
        i_EI = 1'b1;
        i_DI = 1'b1;
        mcycle(1'b1);
        i_EI = 1'b0;
        i_DI = 1'b0;
        mcycle(1'b1);
        chk("ei_di_same", o_IME, 1'b0);

        // EI, then the next instruction end takes IRQ 2
        i_EI = 1'b1;
        mcycle(1'b1);
        i_EI = 1'b0;
        i_IF = 5'b00100;
        i_IE = 5'b00100;
        mcycle(1'b1);
        chk("d1_active", o_INT_Active, 1'b1);
        chk("d1_ime",    o_IME, 1'b0);
        chk("d1_count0", o_Cycle_Count, 8'h01);
        repeat (12) tick();
        chk("d1_count_m4", o_Cycle_Count, 8'h08);
        chk("d1_ack_pre",  o_INT_Ack, 5'b0);
        tick();
        chk("d1_vector", o_INT_Vector, 8'h50);
        chk("d1_ack",    o_INT_Ack, 5'b00100);
        tick();
        chk("d1_ack_pulse", o_INT_Ack, 5'b0);
        i_IF = 5'b0;
        i_IE = 5'b0;
        repeat (5) tick();
        chk("d1_still_active", o_INT_Active, 1'b1);
        chk("d1_count_m5",     o_Cycle_Count, 8'h10);
        tick();
        chk("d1_done",       o_INT_Active, 1'b0);
        chk("d1_count_done", o_Cycle_Count, 8'h01);

        // RETI-style immediate enable, lowest pending line wins
        i_EI_Now = 1'b1;
        mcycle(1'b1);
        i_EI_Now = 1'b0;
        chk("ei_now", o_IME, 1'b1);
        i_IF = 5'b00011;
        i_IE = 5'b00011;
        mcycle(1'b1);
        chk("d2_active", o_INT_Active, 1'b1);
        repeat (13) tick();
        chk("d2_vector", o_INT_Vector, 8'h40);
        chk("d2_ack",    o_INT_Ack, 5'b00001);
        repeat (7) tick();
        chk("d2_done", o_INT_Active, 1'b0);
        i_IF = 5'b0;
        i_IE = 5'b0;

        // HALT with IME=0, wake without dispatch
        i_HALT = 1'b1;
        mcycle(1'b1);
        i_HALT = 1'b0;
        chk("h_enter", o_Halted, 1'b1);
        mcycle(1'b0);
        chk("h_hold",       o_Halted, 1'b1);
        chk("h_count_hold", o_Cycle_Count, 8'h01);
        i_IF = 5'b10000;
        i_IE = 5'b10000;
        repeat (3) tick();
        chk("h_wait_boundary", o_Halted, 1'b1);
        tick();
        chk("h_wake",        o_Halted, 1'b0);
        chk("h_no_dispatch", o_INT_Active, 1'b0);

        // HALT with IME=0 and interrupt already pending: HALT bug for one M-cycle
        i_HALT = 1'b1;
        mcycle(1'b1);
        i_HALT = 1'b0;
        chk("bug_not_halted", o_Halted, 1'b0);
        chk("bug_set",        o_HALT_Bug, 1'b1);
        repeat (3) tick();
        chk("bug_held", o_HALT_Bug, 1'b1);
        tick();
        chk("bug_clear", o_HALT_Bug, 1'b0);
        i_IF = 5'b0;
        i_IE = 5'b0;

        // IF withdrawn before M4: cancelled dispatch
        i_EI_Now = 1'b1;
        mcycle(1'b1);
        i_EI_Now = 1'b0;
        i_IF = 5'b00010;
        i_IE = 5'b00010;
        mcycle(1'b1);
        chk("d3_active", o_INT_Active, 1'b1);
        repeat (12) tick();
        i_IF = 5'b0;
        tick();
        chk("d3_cancel_vec", o_INT_Vector, 8'h00);
        chk("d3_cancel_ack", o_INT_Ack, 5'b0);
        repeat (7) tick();
        chk("d3_done", o_INT_Active, 1'b0);

        // HALT with IME=1 exits straight into dispatch, then reset mid-dispatch
        i_EI_Now = 1'b1;
        mcycle(1'b1);
        i_EI_Now = 1'b0;
        i_HALT = 1'b1;
        mcycle(1'b1);
        i_HALT = 1'b0;
        chk("h2_halted", o_Halted, 1'b1);
        chk("h2_ime",    o_IME, 1'b1);
        i_IF = 5'b00001;
        i_IE = 5'b00001;
        repeat (4) tick();
        chk("h2_wake",   o_Halted, 1'b0);
        chk("h2_active", o_INT_Active, 1'b1);
        chk("h2_ime_clr", o_IME, 1'b0);
        repeat (13) tick();
        chk("h2_vector", o_INT_Vector, 8'h40);
        chk("h2_ack",    o_INT_Ack, 5'b00001);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("mrst_step",   o_Cycle_Step, 4'b0001);
        chk("mrst_count",  o_Cycle_Count, 8'h01);
        chk("mrst_active", o_INT_Active, 1'b0);
        chk("mrst_vector", o_INT_Vector, 8'h00);
        chk("mrst_ack",    o_INT_Ack, 5'b0);
        chk("mrst_ime",    o_IME, 1'b0);
        chk("mrst_halted", o_Halted, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
